// File: rtl/freq_meter_if.sv
// Host-side bundle for freq_meter: run control, raw measured inputs and the latched result set.
interface freq_meter_if;
  logic        En;
  logic        Sig_A;
  logic        Sig_B;
  logic [31:0] fxCnt;
  logic [31:0] fbaseCnt;
  logic [31:0] dutyCnt;
  logic [31:0] delayCnt;
  logic        Do_sig;
  logic        Busy;
  logic        Timeout;

  modport master (
    output En, Sig_A, Sig_B,
    input  fxCnt, fbaseCnt, dutyCnt, delayCnt, Do_sig, Busy, Timeout
  );

  modport slave (
    input  En, Sig_A, Sig_B,
    output fxCnt, fbaseCnt, dutyCnt, delayCnt, Do_sig, Busy, Timeout
  );
endinterface

// File: rtl/freq_meter.sv
// Reciprocal frequency / duty / A->B delay meter; gate opens and closes on Sig_A rising edges.
//  state | meaning
//  IDLE  | parked, waits for En
//  ARM   | waits for the gate-opening A edge (bounded by TIMEOUT_CYCLES)
//  GATE  | preset gate time running, A edges only counted
//  CLOSE | waits for the gate-closing A edge (bounded by TIMEOUT_CYCLES)
//  DONE  | one cycle: latch results, schedule Do_sig
//  HOLD  | quiet time for the packet sender before re-arming
module freq_meter #(
  parameter int unsigned GATE_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned HOLD_CYCLES    = 1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  freq_meter_if.slave mif
);

  localparam int GW = (GATE_CYCLES    > 1) ? $clog2(GATE_CYCLES)    : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;

  // The opening cycle t0 already counts as gate cycle 0, so GATE needs GATE_CYCLES-1 more.
  localparam logic [GW-1:0] GATE_LOAD = GW'((GATE_CYCLES    > 2) ? GATE_CYCLES - 2    : 0);
  localparam logic [TW-1:0] TO_LOAD   = TW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES    > 1) ? HOLD_CYCLES - 1    : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_GATE  = 3'd2;
  localparam logic [2:0] S_CLOSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic [2:0]    sa_q, sb_q;
  logic          sync_a, rise_a, rise_b;

  logic [2:0]    state_q, state_d;
  logic [GW-1:0] gate_tmr_q, gate_tmr_d;
  logic [TW-1:0] to_tmr_q, to_tmr_d;
  logic [HW-1:0] hold_tmr_q, hold_tmr_d;

  logic [31:0]   fx_q, fx_d;
  logic [31:0]   fbase_q, fbase_d;
  logic [31:0]   duty_q, duty_d;
  logic [31:0]   dly_q, dly_d;
  logic          dly_hit_q, dly_hit_d;
  logic          tmo_q, tmo_d;

  logic [31:0]   fx_o_q, fx_o_d;
  logic [31:0]   fbase_o_q, fbase_o_d;
  logic [31:0]   duty_o_q, duty_o_d;
  logic [31:0]   dly_o_q, dly_o_d;
  logic          tmo_o_q, tmo_o_d;
  logic          do_q, do_d;

  logic          accum;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    sat_inc = (inc && (v != ALL_ONES)) ? v + 32'd1 : v;
  endfunction

  // Two sync stages plus one history stage; both channels share identical latency.
  assign sync_a = sa_q[1];
  assign rise_a = sa_q[1] & ~sa_q[2];
  assign rise_b = sb_q[1] & ~sb_q[2];

  always_comb begin
    state_d    = state_q;
    gate_tmr_d = gate_tmr_q;
    to_tmr_d   = to_tmr_q;
    hold_tmr_d = hold_tmr_q;
    fx_d       = fx_q;
    fbase_d    = fbase_q;
    duty_d     = duty_q;
    dly_d      = dly_q;
    dly_hit_d  = dly_hit_q;
    tmo_d      = tmo_q;
    fx_o_d     = fx_o_q;
    fbase_o_d  = fbase_o_q;
    duty_o_d   = duty_o_q;
    dly_o_d    = dly_o_q;
    tmo_o_d    = tmo_o_q;
    do_d       = 1'b0;
    accum      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mif.En) begin
          state_d  = S_ARM;
          to_tmr_d = TO_LOAD;
        end
      end

      S_ARM: begin
        if (rise_a) begin
          state_d    = (GATE_CYCLES > 1) ? S_GATE : S_CLOSE;
          gate_tmr_d = GATE_LOAD;
          to_tmr_d   = TO_LOAD;
          fx_d       = 32'd0;
          fbase_d    = 32'd1;
          duty_d     = 32'd1;
          dly_hit_d  = rise_b;
          dly_d      = rise_b ? 32'd0 : 32'd1;
          tmo_d      = 1'b0;
        end else if (to_tmr_q == '0) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end else begin
          to_tmr_d = to_tmr_q - TW'(1);
        end
      end

      S_GATE: begin
        accum = 1'b1;
        if (gate_tmr_q == '0) begin
          state_d  = S_CLOSE;
          to_tmr_d = TO_LOAD;
        end else begin
          gate_tmr_d = gate_tmr_q - GW'(1);
        end
      end

      S_CLOSE: begin
        // The closing edge is a counted period but lies outside the [t0,t1) base window.
        if (rise_a) begin
          fx_d    = sat_inc(fx_q, 1'b1);
          state_d = S_DONE;
        end else if (to_tmr_q == '0) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end else begin
          accum    = 1'b1;
          to_tmr_d = to_tmr_q - TW'(1);
        end
      end

      S_DONE: begin
        do_d       = 1'b1;
        state_d    = S_HOLD;
        hold_tmr_d = HOLD_LOAD;
        tmo_o_d    = tmo_q;
        if (tmo_q) begin
          fx_o_d    = 32'd0;
          fbase_o_d = 32'd0;
          duty_o_d  = 32'd0;
          dly_o_d   = ALL_ONES;
        end else begin
          fx_o_d    = fx_q;
          fbase_o_d = fbase_q;
          duty_o_d  = duty_q;
          dly_o_d   = dly_hit_q ? dly_q : ALL_ONES;
        end
      end

      S_HOLD: begin
        if (hold_tmr_q == '0) begin
          if (mif.En) begin
            state_d  = S_ARM;
            to_tmr_d = TO_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          hold_tmr_d = hold_tmr_q - HW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (accum) begin
      fx_d    = sat_inc(fx_q, rise_a);
      fbase_d = sat_inc(fbase_q, 1'b1);
      duty_d  = sat_inc(duty_q, sync_a);
      if (!dly_hit_q) begin
        if (rise_b) dly_hit_d = 1'b1;
        else        dly_d     = sat_inc(dly_q, 1'b1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sa_q       <= '0;
      sb_q       <= '0;
      state_q    <= S_IDLE;
      gate_tmr_q <= '0;
      to_tmr_q   <= '0;
      hold_tmr_q <= '0;
      fx_q       <= '0;
      fbase_q    <= '0;
      duty_q     <= '0;
      dly_q      <= '0;
      dly_hit_q  <= 1'b0;
      tmo_q      <= 1'b0;
      fx_o_q     <= '0;
      fbase_o_q  <= '0;
      duty_o_q   <= '0;
      dly_o_q    <= '0;
      tmo_o_q    <= 1'b0;
      do_q       <= 1'b0;
    end else begin
      sa_q       <= {sa_q[1:0], mif.Sig_A};
      sb_q       <= {sb_q[1:0], mif.Sig_B};
      state_q    <= state_d;
      gate_tmr_q <= gate_tmr_d;
      to_tmr_q   <= to_tmr_d;
      hold_tmr_q <= hold_tmr_d;
      fx_q       <= fx_d;
      fbase_q    <= fbase_d;
      duty_q     <= duty_d;
      dly_q      <= dly_d;
      dly_hit_q  <= dly_hit_d;
      tmo_q      <= tmo_d;
      fx_o_q     <= fx_o_d;
      fbase_o_q  <= fbase_o_d;
      duty_o_q   <= duty_o_d;
      dly_o_q    <= dly_o_d;
      tmo_o_q    <= tmo_o_d;
      do_q       <= do_d;
    end
  end

  assign mif.fxCnt    = fx_o_q;
  assign mif.fbaseCnt = fbase_o_q;
  assign mif.dutyCnt  = duty_o_q;
  assign mif.delayCnt = dly_o_q;
  assign mif.Timeout  = tmo_o_q;
  assign mif.Do_sig   = do_q;
  assign mif.Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with short gate/timeout/hold settings.
`timescale 1ns/1ps
module tb_freq_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  freq_meter_if mif();

  freq_meter #(
    .GATE_CYCLES   (100),
    .TIMEOUT_CYCLES(1000),
    .HOLD_CYCLES   (50)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .mif(mif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // waveform generator settings; bmode 0 = B tied low, 1 = A delayed by bdly, 2 = B equals A
  int g_per   = 20;
  int g_high  = 5;
  int g_bmode = 1;
  int g_bdly  = 7;
  int ph      = 19;
  logic [63:0] hist = '0;

  int   do_cnt    = 0;
  int   width_err = 0;
  int   stab_err  = 0;
  logic do_prev   = 1'b0;
  logic rst_prev  = 1'b1;
  logic [128:0] p_vec = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_gen(input int per, input int high, input int bmode, input int bdly);
    g_per   = per;
    g_high  = high;
    g_bmode = bmode;
    g_bdly  = bdly;
    ph      = (per > 0) ? per - 1 : 0;
  endtask

  task automatic wait_do(input int budget, input string tag, output int stamp);
    int n;
    n = 0;
    @(negedge clk);
    while (!mif.Do_sig && n < budget) begin
      @(negedge clk);
      n++;
    end
    stamp = cyc;
    chk({tag, "_do_seen"}, {31'd0, mif.Do_sig}, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [31:0] fx, input logic [31:0] fb,
                           input logic [31:0] du, input logic [31:0] dl, input logic to);
    chk({tag, "_fx"},      mif.fxCnt,    fx);
    chk({tag, "_fbase"},   mif.fbaseCnt, fb);
    chk({tag, "_duty"},    mif.dutyCnt,  du);
    chk({tag, "_delay"},   mif.delayCnt, dl);
    chk({tag, "_timeout"}, {31'd0, mif.Timeout}, {31'd0, to});
  endtask

  initial begin
    logic a;
    mif.Sig_A = 1'b0;
    mif.Sig_B = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (g_per == 0) begin
        a = 1'b0;
      end else begin
        ph = (ph + 1 >= g_per) ? 0 : ph + 1;
        a  = (ph < g_high);
      end
      hist = {hist[62:0], a};
      mif.Sig_A = a;
      case (g_bmode)
        0:       mif.Sig_B = 1'b0;
        1:       mif.Sig_B = hist[g_bdly];
        default: mif.Sig_B = a;
      endcase
    end
  end

  // Do_sig width and output stability outside Do_sig cycles
  initial begin
    logic [128:0] v;
    forever begin
      @(negedge clk);
      v = {mif.fxCnt, mif.fbaseCnt, mif.dutyCnt, mif.delayCnt, mif.Timeout};
      if (mif.Do_sig && !do_prev) do_cnt++;
      if (mif.Do_sig && do_prev)  width_err++;
      if (!mif.Do_sig && !rst && !rst_prev && (v !== p_vec)) stab_err++;
      p_vec    = v;
      do_prev  = mif.Do_sig;
      rst_prev = rst;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_a, t_b, t_prev, sp, min_sp, c0;
    mif.En = 1'b0;
    set_gen(20, 5, 1, 7);

    // reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_fx",      mif.fxCnt, 32'd0);
    chk("rst_fbase",   mif.fbaseCnt, 32'd0);
    chk("rst_delay",   mif.delayCnt, 32'd0);
    chk("rst_do",      {31'd0, mif.Do_sig}, 32'd0);
    chk("rst_busy",    {31'd0, mif.Busy}, 32'd0);
    chk("rst_timeout", {31'd0, mif.Timeout}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, mif.Busy}, 32'd0);
    mif.En = 1'b1;
    @(negedge clk);
    chk("arm_busy", {31'd0, mif.Busy}, 32'd1);

    // 1: period 20 / high 5, B = A delayed 7
    wait_do(500, "t1", t_a);
    check_res("t1", 32'd5, 32'd100, 32'd25, 32'd7, 1'b0);

    // 2: period 37 / high 10, B tied low
    set_gen(37, 10, 0, 0);
    wait_do(600, "t2", t_a);
    check_res("t2", 32'd3, 32'd111, 32'd30, 32'hFFFF_FFFF, 1'b0);

    // 4: B identical to A, five results
    set_gen(20, 5, 2, 0);
    min_sp = 1_000_000;
    wait_do(600, "t4_0", t_prev);
    chk("t4_0_delay", mif.delayCnt, 32'd0);
    for (int i = 1; i < 5; i++) begin
      wait_do(600, "t4_n", t_b);
      chk("t4_n_delay", mif.delayCnt, 32'd0);
      sp = t_b - t_prev;
      if (sp < min_sp) min_sp = sp;
      t_prev = t_b;
    end
    chk("t4_fx", mif.fxCnt, 32'd5);
    chk("t4_spacing_ge150", {31'd0, (min_sp >= 150)}, 32'd1);

    // 3: Sig_A held low -> repeated timeouts
    set_gen(0, 0, 0, 0);
    wait_do(1500, "t3a", t_a);
    check_res("t3a", 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    repeat (500) @(negedge clk);
    chk("t3_timeout_held", {31'd0, mif.Timeout}, 32'd1);
    chk("t3_no_do_mid", {31'd0, mif.Do_sig}, 32'd0);
    wait_do(1500, "t3b", t_b);
    check_res("t3b", 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    chk("t3_interval", t_b - t_a, 32'd1051);

    // 5: one-cycle reset mid-gate
    set_gen(20, 5, 1, 7);
    repeat (110) @(negedge clk);
    chk("t5_busy_pre", {31'd0, mif.Busy}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_fx",      mif.fxCnt, 32'd0);
    chk("t5_delay",   mif.delayCnt, 32'd0);
    chk("t5_timeout", {31'd0, mif.Timeout}, 32'd0);
    chk("t5_busy",    {31'd0, mif.Busy}, 32'd0);
    c0 = do_cnt;
    repeat (80) @(negedge clk);
    chk("t5_no_abort_do", do_cnt - c0, 32'd0);
    wait_do(500, "t5", t_a);
    check_res("t5", 32'd5, 32'd100, 32'd25, 32'd7, 1'b0);

    // 6: En dropped mid-gate
    repeat (110) @(negedge clk);
    mif.En = 1'b0;
    wait_do(400, "t6", t_a);
    check_res("t6", 32'd5, 32'd100, 32'd25, 32'd7, 1'b0);
    repeat (60) @(negedge clk);
    chk("t6_idle_busy", {31'd0, mif.Busy}, 32'd0);
    c0 = do_cnt;
    repeat (300) @(negedge clk);
    chk("t6_no_do_idle", do_cnt - c0, 32'd0);
    mif.En = 1'b1;
    @(negedge clk);
    chk("t6_rearm_busy", {31'd0, mif.Busy}, 32'd1);
    wait_do(500, "t6r", t_a);
    check_res("t6r", 32'd5, 32'd100, 32'd25, 32'd7, 1'b0);

    repeat (5) @(negedge clk);
    chk("do_width",   width_err, 32'd0);
    chk("out_stable", stab_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
